// File: rtl/ifu_pc_ir.sv
// ---------------------------------------------------------------------------
// ifu_pc_ir : instruction-fetch stage of the multi-cycle MIPS datapath.
//
// Holds the program counter, presents the instruction-memory byte address,
// latches the returned word into the instruction register and selects the
// next PC (sequential, branch, jump, jr) under control of the multi-cycle
// controller.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-low reset
//   pc_wr       : PC write enable
//   ir_wr       : IR write enable (one fetch per asserted edge)
//   npc_sel     : next-PC source 00=PC+4 01=branch 10=jump 11=jr
//   br_cond     : branch taken condition, used only when npc_sel=01
//   rs_data     : jr target, used only when npc_sel=11
//   im_dout     : word returned by the asynchronous instruction memory
//   im_addr     : byte address to instruction memory (pc[11:0])
//   pc          : current program counter
//   ir          : instruction register
//   fetch_fault : sticky out-of-range / misaligned fetch flag
//   fetch_cnt   : number of IR loads since reset, wraps modulo 2^32
//
// IM_BYTES must be a power of two no larger than 4096 and IM_BASE must be
// aligned to IM_BYTES, because the memory indexes pc[11:0] directly.
// ---------------------------------------------------------------------------
module ifu_pc_ir #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic        ir_wr,
    input  logic [1:0]  npc_sel,
    input  logic        br_cond,
    input  logic [31:0] rs_data,
    input  logic [31:0] im_dout,
    output logic [11:0] im_addr,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    // Highest legal word address inside the instruction memory window.
    localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_BYTES) - 32'd4;

    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic        fault_r;
    logic [31:0] cnt_r;

    logic [31:0] seq_s;
    logic [31:0] br_s;
    logic [31:0] jmp_s;
    logic [31:0] next_pc_s;
    logic        pc_load_s;
    logic        fault_s;

    // Branch offset: sign-extended word offset converted to a byte offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Candidate next-PC values from the current pc and the already-latched ir.
    always_comb begin
        seq_s = pc_r + 32'd4;
        br_s  = pc_r + br_offset(ir_r[15:0]);
        jmp_s = {pc_r[31:28], ir_r[25:0], 2'b00};
    end

    // Next-PC select; a not-taken branch suppresses the load so pc holds.
    always_comb begin
        next_pc_s = seq_s;
        pc_load_s = 1'b0;
        case (npc_sel)
            2'b00: begin
                next_pc_s = seq_s;
                pc_load_s = 1'b1;
            end
            2'b01: begin
                next_pc_s = br_s;
                pc_load_s = br_cond;
            end
            2'b10: begin
                next_pc_s = jmp_s;
                pc_load_s = 1'b1;
            end
            2'b11: begin
                next_pc_s = rs_data;
                pc_load_s = 1'b1;
            end
            default: begin
                next_pc_s = seq_s;
                pc_load_s = 1'b0;
            end
        endcase
    end

    // Fault condition on the address being fetched this cycle.
    always_comb begin
        fault_s = (pc_r < IM_BASE) || (pc_r > IM_LAST) || (pc_r[1:0] != 2'b00);
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r <= PC_RESET;
        end else if (pc_wr && pc_load_s) begin
            pc_r <= next_pc_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction register and fetch counter; both advance on each IR load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_r  <= 32'h0000_0000;
            cnt_r <= 32'd0;
        end else if (ir_wr) begin
            ir_r  <= im_dout;
            cnt_r <= cnt_r + 32'd1;
        end else begin
            ir_r  <= ir_r;
            cnt_r <= cnt_r;
        end
    end

    // Sticky fault flag; the fetch itself still completes, halting is the
    // controller's job.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_r <= 1'b0;
        end else if (ir_wr && fault_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign im_addr     = pc_r[11:0];
    assign pc          = pc_r;
    assign ir          = ir_r;
    assign fetch_fault = fault_r;
    assign fetch_cnt   = cnt_r;

endmodule

// File: tb/tb_ifu_pc_ir.sv
module tb_ifu_pc_ir;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_wr = 1'b0;
    logic        ir_wr = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        br_cond = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] im_dout;
    logic [11:0] im_addr;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    // Instruction memory: 4 KB byte space, indexed by the low address bits.
    logic [31:0] imem [0:1023];
    assign im_dout = imem[im_addr[11:2]];

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;
    logic [31:0] m_cnt;

    ifu_pc_ir dut (
        .clk(clk), .rst(rst), .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel),
        .br_cond(br_cond), .rs_data(rs_data), .im_dout(im_dout), .im_addr(im_addr),
        .pc(pc), .ir(ir), .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the model from the architectural rules, and
    // leave the bench 1 time unit after the edge.
    task automatic step(input logic r, input logic pw, input logic iw,
                        input logic [1:0] sel, input logic bc, input logic [31:0] rs);
        logic [31:0] nxt;
        logic        load;
        logic        bad;
        rst = r; pc_wr = pw; ir_wr = iw; npc_sel = sel; br_cond = bc; rs_data = rs;
        if (!r) begin
            m_pc = 32'h3000; m_ir = 32'h0; m_fault = 1'b0; m_cnt = 32'h0;
        end else begin
            load = 1'b1;
            case (sel)
                2'b00: nxt = m_pc + 32'd4;
                2'b01: begin
                    nxt  = m_pc + 32'(int'($signed(m_ir[15:0])) * 4);
                    load = bc;
                end
                2'b10: nxt = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
                default: nxt = rs;
            endcase
            bad = (m_pc < 32'h3000) || (m_pc > 32'h33FC) || ((m_pc % 4) != 0);
            if (iw) begin
                m_ir  = imem[(m_pc % 4096) / 4];
                m_cnt = m_cnt + 1;
                if (bad) m_fault = 1'b1;
            end
            if (pw && load) m_pc = nxt;
        end
        @(posedge clk);
        #1;
        rst = 1'b1; pc_wr = 1'b0; ir_wr = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h want 00003000", pc); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", ir); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
    endtask

    task automatic test_fetch();
        logic [11:0] want_addr [3] = '{12'h000, 12'h004, 12'h008};
        imem[0] = 32'h2008_0005; imem[1] = 32'h2009_0003; imem[2] = 32'h0109_5020;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (im_addr !== want_addr[i]) begin errors++; $display("FAIL fetch_addr%0d: got %h want %h", i, im_addr, want_addr[i]); end
            step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        end
        checks++; if (pc !== 32'h0000_300C) begin errors++; $display("FAIL fetch_pc: got %h want 0000300c", pc); end
        checks++; if (ir !== 32'h0109_5020) begin errors++; $display("FAIL fetch_ir: got %h want 01095020", ir); end
        checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL fetch_cnt: got %0d want 3", fetch_cnt); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fetch_fault: got %b want 0", fetch_fault); end
    endtask

    task automatic test_branch();
        imem[2] = 32'h1000_FFFE;
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3008);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'hDEAD_BEEF);
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL br_back: got %h want 00003000", pc); end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3008);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'hDEAD_BEEF);
        checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL br_not_taken: got %h want 00003008", pc); end
        imem[2] = 32'h1000_0003;
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0);
        checks++; if (pc !== 32'h3014) begin errors++; $display("FAIL br_fwd: got %h want 00003014", pc); end
        checks++; if (pc !== m_pc) begin errors++; $display("FAIL br_model: got %h want %h", pc, m_pc); end
    endtask

    task automatic test_jump();
        imem[4] = 32'h0800_0C03;
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3010);
        step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
        checks++; if (ir !== 32'h0800_0C03) begin errors++; $display("FAIL j_ir: got %h want 08000c03", ir); end
        step(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
        checks++; if (pc !== 32'h0000_300C) begin errors++; $display("FAIL j_pc: got %h want 0000300c", pc); end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3020);
        checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL jr_pc: got %h want 00003020", pc); end
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 1'b0, 1'b0, 2'(s), 1'b1, 32'h1234_5678);
            checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL hold_sel%0d: got %h want 00003020", s, pc); end
        end
    endtask

    task automatic test_boundary();
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h33F8);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL bound_last_legal: got %b want 0", fetch_fault); end
        checks++; if (pc !== 32'h3400) begin errors++; $display("FAIL bound_pc: got %h want 00003400", pc); end
        checks++; if (im_addr !== 12'h400) begin errors++; $display("FAIL bound_alias: got %h want 400", im_addr); end
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL bound_fault: got %b want 1", fetch_fault); end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3000);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
            checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL sticky%0d: got %b want 1", i, fetch_fault); end
        end
    endtask

    task automatic test_align();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL align_clear: got %b want 0", fetch_fault); end
        step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h3002);
        checks++; if (pc !== 32'h3002) begin errors++; $display("FAIL align_jr: got %h want 00003002", pc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL align_early: got %b want 0", fetch_fault); end
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL align_fault: got %b want 1", fetch_fault); end
        checks++; if (pc !== 32'h3006) begin errors++; $display("FAIL align_pc: got %h want 00003006", pc); end
    endtask

    task automatic test_midreset();
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0);
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL mid_pc: got %h want 00003000", pc); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL mid_ir: got %h want 0", ir); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", fetch_cnt); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mid_fault: got %b want 0", fetch_fault); end
        checks++; if (im_addr !== 12'h000) begin errors++; $display("FAIL mid_addr: got %h want 000", im_addr); end
        step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0);
        checks++; if (ir !== imem[0]) begin errors++; $display("FAIL mid_first_ir: got %h want %h", ir, imem[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs;
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            rs = ($urandom_range(0, 7) == 0) ? $urandom() : (32'h3000 + 32'($urandom_range(0, 1023)));
            step(($urandom_range(0, 49) != 0), 1'($urandom()), 1'($urandom()), 2'($urandom()), 1'($urandom()), rs);
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc, m_pc); end
            checks++; if (ir !== m_ir) begin errors++; $display("FAIL rnd_ir@%0d: got %h want %h", i, ir, m_ir); end
            checks++; if (fetch_fault !== m_fault) begin errors++; $display("FAIL rnd_fault@%0d: got %b want %b", i, fetch_fault, m_fault); end
            checks++; if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, fetch_cnt, m_cnt); end
            checks++; if (im_addr !== m_pc[11:0]) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", i, im_addr, m_pc[11:0]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = $urandom();
        m_pc = 32'h3000; m_ir = 32'h0; m_fault = 1'b0; m_cnt = 32'h0;
        #1;
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_boundary();
        test_align();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_pc_ir.md
Name: ifu_pc_ir

Overview:
- Instruction-fetch stage for the multi-cycle MIPS datapath, directly upstream of the instruction memory.
- Holds the program counter (PC), drives the memory byte address, and computes the next PC for sequential, branch, jump and jr flow.
- Latches the 32-bit big-endian instruction word returned by the memory into the instruction register (IR).
- The multi-cycle controller sequences it through pc_wr and ir_wr; decode and execute consume IR and PC.

Parameters:
- PC_RESET, 32'h0000_3000: PC value after reset.
- IM_BASE, 32'h0000_3000: first byte address backed by instruction memory.
- IM_BYTES, 1024: instruction memory size in bytes; must be a power of two and at most 4096.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous, active-low.
- pc_wr, in, 1: PC write enable.
- ir_wr, in, 1: IR write enable.
- npc_sel, in, 2: next-PC source. 00 = PC+4, 01 = branch, 10 = jump, 11 = jr.
- br_cond, in, 1: branch condition (e.g. ALU zero); only meaningful when npc_sel=01.
- rs_data, in, 32: register value used as the jr target.
- im_dout, in, 32: instruction word returned by instruction memory.
- im_addr, out, 12: byte address to instruction memory.
- pc, out, 32: current PC.
- ir, out, 32: instruction register.
- fetch_fault, out, 1: sticky fetch-range / alignment fault.
- fetch_cnt, out, 32: number of IR loads since reset.

Behaviour:
- Reset values (rst=0 at a rising edge): pc=PC_RESET, ir=0, fetch_fault=0, fetch_cnt=0. Reset overrides pc_wr and ir_wr in the same cycle.
- im_addr = pc[11:0], purely combinational. No base subtraction: the memory indexes its low bits directly, so IM_BASE must be aligned to IM_BYTES.
- Instruction memory is asynchronous. im_dout is valid in the same cycle im_addr is presented, and the IR captures it at that cycle's edge (zero-wait fetch).
- IR update: when ir_wr=1, ir <= im_dout at the edge. The value captured corresponds to the pre-edge pc. ir holds otherwise.
- fetch_cnt increments by 1 on every edge with ir_wr=1 and wraps modulo 2^32.
- Next-PC computation (combinational from the current pc and ir):
  - seq = pc + 4.
  - br = pc + (sign_extend(ir[15:0]) << 2). pc here already holds the branch instruction's address + 4, because the fetch cycle wrote PC+4.
  - jmp = {pc[31:28], ir[25:0], 2'b00}.
  - jr = rs_data.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- PC update by npc_sel, applied only when pc_wr=1:
  - 00: pc <= seq.
  - 01: pc <= br if br_cond=1; pc holds if br_cond=0.
  - 10: pc <= jmp.
  - 11: pc <= jr.
  - pc_wr=0: pc holds regardless of npc_sel.
- Simultaneous pc_wr=1 and ir_wr=1 (normal fetch cycle):
  - IR gets the word at the old pc and pc moves to the new value.
  - npc_sel computations use the old ir, not the word being loaded.
- Fault detection, evaluated every cycle on the current pc. A fault condition is either:
  - pc < IM_BASE, or
  - pc > IM_BASE + IM_BYTES - 4, or
  - pc[1:0] != 0.
- On an edge with ir_wr=1 and a fault condition true, fetch_fault <= 1.
  - It stays 1 until reset.
  - The IR still loads im_dout and the PC still updates. The controller is responsible for halting.
- Range boundaries:
  - pc = IM_BASE + IM_BYTES - 4 (0x33FC with defaults) is legal.
  - PC+4 from that address gives 0x3400, which faults on the next fetch. im_addr then aliases to 0x400, and the memory output is don't-care.
- jr with an unaligned rs_data loads pc verbatim (no masking). The fault is raised at the next fetch.
- Reset asserted mid-sequence (between fetch and write-back) discards all in-flight state on that edge. The first post-reset fetch reads PC_RESET.
- No X propagation from unused inputs: rs_data is ignored unless npc_sel=11, and br_cond is ignored unless npc_sel=01.

Test Plan:
1. Reset then 3 fetch cycles (pc_wr=ir_wr=1, npc_sel=00), with memory returning 0x20080005, 0x20090003, 0x01095020 → im_addr 0x000/0x004/0x008, pc ends 0x0000300C, ir=0x01095020, fetch_cnt=3, fetch_fault=0.
2. Branch: pc=0x3008, ir imm16=0xFFFE, npc_sel=01, pc_wr=1:
   - br_cond=1 → pc=0x3000.
   - Repeat with br_cond=0 → pc stays 0x3008.
   - imm16=0x0003, br_cond=1 → pc=0x3014.
3. Jump/jr:
   - pc=0x3010, ir=0x08000C03, npc_sel=10 → pc=0x0000300C.
   - npc_sel=11, rs_data=0x00003020 → pc=0x3020.
   - pc_wr=0 with any npc_sel → pc unchanged.
4. Range boundary: walk pc to 0x33FC and fetch → no fault. Next fetch at 0x3400 → fetch_fault=1, im_addr=0x400. fetch_fault stays 1 through 5 further legal fetches.
5. Alignment: jr to 0x3002, then fetch → fetch_fault=1, pc=0x3006 after the fetch.
6. Reset mid-operation: assert rst=0 on a cycle with pc_wr=ir_wr=1, npc_sel=10 → pc=0x3000, ir=0, fetch_cnt=0, fetch_fault=0 next cycle. Deassert; next fetch im_addr=0x000.
